// File: rtl/plab3_mem_cache_l2_pkg.sv
// Shared encodings for the blocking L2 cache control unit:
// FSM states, memory message types and AMO unit selects.
package plab3_mem_cache_l2_pkg;

  localparam int unsigned NSETS = 8;
  localparam int unsigned NWAYS = 2;
  localparam int unsigned IDX_W = 3;

  typedef enum logic [3:0] {
    ST_IDLE,
    ST_TAG_CHECK,
    ST_EVICT_PREP,
    ST_EVICT_REQ,
    ST_EVICT_WAIT,
    ST_REFILL_REQ,
    ST_REFILL_WAIT,
    ST_REFILL_UPD,
    ST_RD,
    ST_WR,
    ST_AMO_RD,
    ST_AMO_WR,
    ST_RESP
  } state_e;

  localparam logic [2:0] MEM_READ    = 3'd0;
  localparam logic [2:0] MEM_WRITE   = 3'd1;
  localparam logic [2:0] MEM_INIT    = 3'd2;
  localparam logic [2:0] MEM_AMO_ADD = 3'd3;
  localparam logic [2:0] MEM_AMO_AND = 3'd4;
  localparam logic [2:0] MEM_AMO_OR  = 3'd5;

  localparam logic [1:0] AMO_SEL_DATA = 2'd0;
  localparam logic [1:0] AMO_SEL_ADD  = 2'd1;
  localparam logic [1:0] AMO_SEL_AND  = 2'd2;
  localparam logic [1:0] AMO_SEL_OR   = 2'd3;

  function automatic logic type_is_amo(input logic [2:0] t);
    return (t == MEM_AMO_ADD) || (t == MEM_AMO_AND) || (t == MEM_AMO_OR);
  endfunction

  function automatic logic [1:0] amo_sel_of(input logic [2:0] t);
    case (t)
      MEM_AMO_ADD: return AMO_SEL_ADD;
      MEM_AMO_AND: return AMO_SEL_AND;
      MEM_AMO_OR:  return AMO_SEL_OR;
      default:     return AMO_SEL_DATA;
    endcase
  endfunction

endpackage

// File: rtl/plab3_mem_cache_l2_state_bits.sv
// Per-set valid/dirty bits for each way plus one LRU bit per set.
// Asynchronously cleared; updates apply to the set selected by idx_i.
module plab3_mem_cache_l2_state_bits
  import plab3_mem_cache_l2_pkg::*;
(
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic [IDX_W-1:0] idx_i,
  input  logic [NWAYS-1:0] set_valid_i,
  input  logic [NWAYS-1:0] set_dirty_i,
  input  logic [NWAYS-1:0] clr_dirty_i,
  input  logic             lru_wen_i,
  input  logic             lru_way_i,
  output logic [NWAYS-1:0] valid_o,
  output logic [NWAYS-1:0] dirty_o,
  output logic             lru_o
);

  logic [NSETS-1:0][NWAYS-1:0] valid_q;
  logic [NSETS-1:0][NWAYS-1:0] dirty_q;
  logic [NSETS-1:0]            lru_q;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      valid_q <= '0;
      dirty_q <= '0;
      lru_q   <= '0;
    end else begin
      valid_q[idx_i] <= valid_q[idx_i] | set_valid_i;
      // set wins over clear when both are requested for a way
      dirty_q[idx_i] <= (dirty_q[idx_i] & ~clr_dirty_i) | set_dirty_i;
      if (lru_wen_i) lru_q[idx_i] <= lru_way_i;
    end
  end

  assign valid_o = valid_q[idx_i];
  assign dirty_o = dirty_q[idx_i];
  assign lru_o   = lru_q[idx_i];

endmodule

// File: rtl/plab3_mem_blocking_cache_l2_ctrl.sv
// Control FSM for the 2-way, 8-set, write-back/write-allocate blocking L2.
// Optional PLAB3_CACHE_L2_PERF_EN adds saturating hit/miss/evict counters.
module plab3_mem_blocking_cache_l2_ctrl
  import plab3_mem_cache_l2_pkg::*;
#(
  parameter int p_idx_shamt    = 0,
  parameter int p_opaque_nbits = 8
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        cachereq_val,
  output logic        cachereq_rdy,
  output logic        cacheresp_val,
  input  logic        cacheresp_rdy,
  output logic        memreq_val,
  input  logic        memreq_rdy,
  input  logic        memresp_val,
  output logic        memresp_rdy,
  output logic [1:0]  amo_sel,
  output logic        cachereq_en,
  output logic        memresp_en,
  output logic        is_refill,
  output logic        tag_array_0_wen,
  output logic        tag_array_0_ren,
  output logic        tag_array_1_wen,
  output logic        tag_array_1_ren,
  output logic        way_sel,
  output logic        data_array_wen,
  output logic        data_array_ren,
  output logic [15:0] data_array_wben,
  output logic        read_data_reg_en,
  output logic        read_tag_reg_en,
  output logic [2:0]  memreq_type,
  output logic [2:0]  cacheresp_type,
  input  logic [2:0]  cachereq_type,
  input  logic [31:0] cachereq_addr,
  input  logic        tag_match_0,
  input  logic        tag_match_1
`ifdef PLAB3_CACHE_L2_PERF_EN
  ,
  output logic [31:0] hit_cnt,
  output logic [31:0] miss_cnt,
  output logic [31:0] evict_cnt
`endif
);

  state_e           state_q, state_d;
  logic             way_q, way_d;
  logic             hit_q, hit_d;
  logic [IDX_W-1:0] idx;
  logic [NWAYS-1:0] valid, dirty, way_vec;
  logic [NWAYS-1:0] tag_wen, tag_ren, set_valid, set_dirty, clr_dirty;
  logic             lru, lru_wen, hit_0, hit_1, tc_hit, victim;
  logic             is_wr, is_amo, data_wen;
  state_e           access_st;
  logic             unused_ok;

  assign idx       = cachereq_addr[4+p_idx_shamt +: IDX_W];
  assign hit_0     = tag_match_0 & valid[0];
  assign hit_1     = tag_match_1 & valid[1];
  assign tc_hit    = hit_0 | hit_1;
  assign victim    = ~valid[0] ? 1'b0 : (~valid[1] ? 1'b1 : lru);
  assign is_wr     = (cachereq_type == MEM_WRITE) || (cachereq_type == MEM_INIT);
  assign is_amo    = type_is_amo(cachereq_type);
  assign way_vec   = way_q ? 2'b10 : 2'b01;
  assign access_st = is_amo ? ST_AMO_RD : (is_wr ? ST_WR : ST_RD);
  assign unused_ok = ^{cachereq_addr, 32'(p_opaque_nbits)};

  plab3_mem_cache_l2_state_bits u_state_bits (
    .clk_i       (clk),
    .rst_ni      (reset),
    .idx_i       (idx),
    .set_valid_i (set_valid),
    .set_dirty_i (set_dirty),
    .clr_dirty_i (clr_dirty),
    .lru_wen_i   (lru_wen),
    .lru_way_i   (~way_q),
    .valid_o     (valid),
    .dirty_o     (dirty),
    .lru_o       (lru)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= ST_IDLE;
      way_q   <= 1'b0;
      hit_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      way_q   <= way_d;
      hit_q   <= hit_d;
    end
  end

  always_comb begin
    state_d          = state_q;
    way_d            = way_q;
    hit_d            = hit_q;
    cachereq_rdy     = 1'b0;
    cacheresp_val    = 1'b0;
    memreq_val       = 1'b0;
    memresp_rdy      = 1'b0;
    amo_sel          = AMO_SEL_DATA;
    cachereq_en      = 1'b0;
    memresp_en       = 1'b0;
    is_refill        = 1'b0;
    way_sel          = 1'b0;
    data_wen         = 1'b0;
    data_array_ren   = 1'b0;
    read_data_reg_en = 1'b0;
    read_tag_reg_en  = 1'b0;
    memreq_type      = MEM_READ;
    cacheresp_type   = MEM_READ;
    tag_wen          = '0;
    tag_ren          = '0;
    set_valid        = '0;
    set_dirty        = '0;
    clr_dirty        = '0;
    lru_wen          = 1'b0;
    // Outputs are gated while reset is held so IDLE does not advertise rdy.
    if (reset) begin
      unique case (state_q)
        ST_IDLE: begin
          cachereq_rdy = 1'b1;
          cachereq_en  = cachereq_val;
          if (cachereq_val) state_d = ST_TAG_CHECK;
        end
        ST_TAG_CHECK: begin
          tag_ren = '1;
          hit_d   = tc_hit;
          way_d   = tc_hit ? hit_1 : victim;
          if (tc_hit)                          state_d = access_st;
          else if (valid[victim] & dirty[victim]) state_d = ST_EVICT_PREP;
          else if (is_wr)                      state_d = ST_WR;
          else                                 state_d = ST_REFILL_REQ;
        end
        ST_EVICT_PREP: begin
          way_sel          = way_q;
          data_array_ren   = 1'b1;
          tag_ren          = way_vec;
          read_data_reg_en = 1'b1;
          read_tag_reg_en  = 1'b1;
          state_d          = ST_EVICT_REQ;
        end
        ST_EVICT_REQ: begin
          memreq_val  = 1'b1;
          memreq_type = MEM_WRITE;
          if (memreq_rdy) state_d = ST_EVICT_WAIT;
        end
        ST_EVICT_WAIT: begin
          memresp_rdy = 1'b1;
          if (memresp_val) state_d = is_wr ? ST_WR : ST_REFILL_REQ;
        end
        ST_REFILL_REQ: begin
          memreq_val  = 1'b1;
          memreq_type = MEM_READ;
          if (memreq_rdy) state_d = ST_REFILL_WAIT;
        end
        ST_REFILL_WAIT: begin
          memresp_rdy = 1'b1;
          memresp_en  = memresp_val;
          if (memresp_val) state_d = ST_REFILL_UPD;
        end
        ST_REFILL_UPD: begin
          is_refill = 1'b1;
          data_wen  = 1'b1;
          way_sel   = way_q;
          tag_wen   = way_vec;
          set_valid = way_vec;
          clr_dirty = way_vec;
          state_d   = is_amo ? ST_AMO_RD : ST_RD;
        end
        ST_RD: begin
          way_sel          = way_q;
          data_array_ren   = 1'b1;
          read_data_reg_en = 1'b1;
          lru_wen          = 1'b1;
          state_d          = ST_RESP;
        end
        ST_WR: begin
          way_sel   = way_q;
          data_wen  = 1'b1;
          tag_wen   = hit_q ? '0 : way_vec;
          set_valid = way_vec;
          if (cachereq_type == MEM_WRITE) set_dirty = way_vec;
          else                            clr_dirty = way_vec;
          lru_wen   = 1'b1;
          state_d   = ST_RESP;
        end
        ST_AMO_RD: begin
          way_sel          = way_q;
          data_array_ren   = 1'b1;
          read_data_reg_en = 1'b1;
          state_d          = ST_AMO_WR;
        end
        ST_AMO_WR: begin
          way_sel   = way_q;
          data_wen  = 1'b1;
          amo_sel   = amo_sel_of(cachereq_type);
          set_dirty = way_vec;
          lru_wen   = 1'b1;
          state_d   = ST_RESP;
        end
        ST_RESP: begin
          cacheresp_val  = 1'b1;
          cacheresp_type = cachereq_type;
          if (cacheresp_rdy) state_d = ST_IDLE;
        end
        default: state_d = ST_IDLE;
      endcase
    end
  end

  assign tag_array_0_wen = tag_wen[0];
  assign tag_array_1_wen = tag_wen[1];
  assign tag_array_0_ren = tag_ren[0];
  assign tag_array_1_ren = tag_ren[1];
  assign data_array_wen  = data_wen;
  assign data_array_wben = data_wen ? '1 : '0;

`ifdef PLAB3_CACHE_L2_PERF_EN
  logic [31:0] hit_cnt_q, miss_cnt_q, evict_cnt_q;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      hit_cnt_q   <= '0;
      miss_cnt_q  <= '0;
      evict_cnt_q <= '0;
    end else begin
      if (state_q == ST_TAG_CHECK && tc_hit && hit_cnt_q != '1)
        hit_cnt_q <= hit_cnt_q + 32'd1;
      if (state_q == ST_TAG_CHECK && !tc_hit && miss_cnt_q != '1)
        miss_cnt_q <= miss_cnt_q + 32'd1;
      if (state_q == ST_EVICT_REQ && memreq_rdy && evict_cnt_q != '1)
        evict_cnt_q <= evict_cnt_q + 32'd1;
    end
  end

  assign hit_cnt   = hit_cnt_q;
  assign miss_cnt  = miss_cnt_q;
  assign evict_cnt = evict_cnt_q;
`endif

endmodule

// File: tb/tb_plab3_mem_blocking_cache_l2_ctrl.sv
// Bench for the L2 control unit: a cache-state model (tags, valid, dirty, LRU)
// predicts hit/victim/evict/refill and latency for directed and random requests.
module tb_plab3_mem_blocking_cache_l2_ctrl;

  localparam logic [2:0] T_READ  = 3'd0;
  localparam logic [2:0] T_WRITE = 3'd1;
  localparam logic [2:0] T_INIT  = 3'd2;
  localparam logic [2:0] T_ADD   = 3'd3;
  localparam logic [2:0] T_AND   = 3'd4;
  localparam logic [2:0] T_OR    = 3'd5;

  logic        clk = 1'b0;
  logic        reset;
  logic        cachereq_val, cachereq_rdy, cacheresp_val, cacheresp_rdy;
  logic        memreq_val, memreq_rdy, memresp_val, memresp_rdy;
  logic [1:0]  amo_sel;
  logic        cachereq_en, memresp_en, is_refill;
  logic        tag_array_0_wen, tag_array_0_ren, tag_array_1_wen, tag_array_1_ren;
  logic        way_sel, data_array_wen, data_array_ren;
  logic [15:0] data_array_wben;
  logic        read_data_reg_en, read_tag_reg_en;
  logic [2:0]  memreq_type, cacheresp_type, cachereq_type;
  logic [31:0] cachereq_addr;
  logic        tag_match_0, tag_match_1;
  logic [39:0] outs;

  int unsigned checks = 0;
  int unsigned errors = 0;

  // Reference cache state: what the tag array holds plus valid/dirty/LRU.
  logic [24:0] m_tag   [8][2];
  bit          m_val   [8][2];
  bit          m_dirty [8][2];
  bit          m_lru   [8];

  always #5 clk = ~clk;

  assign tag_match_0 = (m_tag[cachereq_addr[6:4]][0] == cachereq_addr[31:7]);
  assign tag_match_1 = (m_tag[cachereq_addr[6:4]][1] == cachereq_addr[31:7]);

  assign outs = {cachereq_rdy, cacheresp_val, memreq_val, memresp_rdy, amo_sel,
                 cachereq_en, memresp_en, is_refill, tag_array_0_wen, tag_array_0_ren,
                 tag_array_1_wen, tag_array_1_ren, way_sel, data_array_wen, data_array_ren,
                 data_array_wben, read_data_reg_en, read_tag_reg_en, memreq_type,
                 cacheresp_type};

  plab3_mem_blocking_cache_l2_ctrl #(
    .p_idx_shamt    (0),
    .p_opaque_nbits (8)
  ) dut (
    .clk              (clk),
    .reset            (reset),
    .cachereq_val     (cachereq_val),
    .cachereq_rdy     (cachereq_rdy),
    .cacheresp_val    (cacheresp_val),
    .cacheresp_rdy    (cacheresp_rdy),
    .memreq_val       (memreq_val),
    .memreq_rdy       (memreq_rdy),
    .memresp_val      (memresp_val),
    .memresp_rdy      (memresp_rdy),
    .amo_sel          (amo_sel),
    .cachereq_en      (cachereq_en),
    .memresp_en       (memresp_en),
    .is_refill        (is_refill),
    .tag_array_0_wen  (tag_array_0_wen),
    .tag_array_0_ren  (tag_array_0_ren),
    .tag_array_1_wen  (tag_array_1_wen),
    .tag_array_1_ren  (tag_array_1_ren),
    .way_sel          (way_sel),
    .data_array_wen   (data_array_wen),
    .data_array_ren   (data_array_ren),
    .data_array_wben  (data_array_wben),
    .read_data_reg_en (read_data_reg_en),
    .read_tag_reg_en  (read_tag_reg_en),
    .memreq_type      (memreq_type),
    .cacheresp_type   (cacheresp_type),
    .cachereq_type    (cachereq_type),
    .cachereq_addr    (cachereq_addr),
    .tag_match_0      (tag_match_0),
    .tag_match_1      (tag_match_1)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    for (int s = 0; s < 8; s++) begin
      m_lru[s] = 1'b0;
      for (int w = 0; w < 2; w++) begin
        m_val[s][w]   = 1'b0;
        m_dirty[s][w] = 1'b0;
      end
    end
  endtask

  // One full request; called at posedge+1. rq: memreq_rdy stall cycles,
  // rs: memresp delay cycles, cr: cacheresp_rdy stall cycles.
  task automatic txn(input logic [2:0] typ, input logic [31:0] addr,
                     input int unsigned rq, input int unsigned rs, input int unsigned cr);
    logic [2:0]  idx, last_mt;
    logic [24:0] tg;
    bit          h0, h1, hit, way, evict, refill, is_wr, is_amo, pending, done;
    int unsigned exp_resp, cyc, req_seen, resp_wait, cr_seen, n_refill, n_wr, n_evrd;
    logic [2:0]  mem_q[$];
    logic [2:0]  exp_q[$];

    idx    = addr[6:4];
    tg     = addr[31:7];
    h0     = m_val[idx][0] && (m_tag[idx][0] == tg);
    h1     = m_val[idx][1] && (m_tag[idx][1] == tg);
    hit    = h0 || h1;
    way    = hit ? h1 : (!m_val[idx][0] ? 1'b0 : (!m_val[idx][1] ? 1'b1 : m_lru[idx]));
    is_wr  = (typ == T_WRITE) || (typ == T_INIT);
    is_amo = (typ >= T_ADD);
    evict  = !hit && m_val[idx][way] && m_dirty[idx][way];
    refill = !hit && !is_wr;
    if (evict)  exp_q.push_back(T_WRITE);
    if (refill) exp_q.push_back(T_READ);
    exp_resp = 2 + (is_amo ? 2 : 1) + (evict ? 3 + rq + rs : 0) + (refill ? 3 + rq + rs : 0);

    cachereq_type = typ;
    cachereq_addr = addr;
    cyc = 0; done = 0; pending = 0; req_seen = 0; resp_wait = 0; cr_seen = 0;
    n_refill = 0; n_wr = 0; n_evrd = 0; last_mt = T_READ;
    while (!done && cyc < 200) begin
      cachereq_val  = (cyc == 0);
      memreq_rdy    = (req_seen >= rq);
      memresp_val   = pending ? (resp_wait >= rs) : 1'($urandom_range(0, 1));
      cacheresp_rdy = (cr_seen >= cr);
      #1;
      if (cyc == 0) begin
        chk("req_rdy_idle", cachereq_rdy, 1);
        chk("req_en_idle", cachereq_en, 1);
      end else begin
        chk("req_rdy_busy", cachereq_rdy, 0);
      end
      if (req_seen > 0) chk("memreq_hold", memreq_val, 1);
      if (cr_seen > 0)  chk("resp_hold", cacheresp_val, 1);
      if (!pending) begin
        chk("stray_memresp", {memresp_rdy, memresp_en}, 0);
      end else if (memresp_val && memresp_rdy) begin
        chk("memresp_en", memresp_en, last_mt == T_READ);
        pending = 0;
      end else begin
        resp_wait++;
      end
      if (memreq_val) begin
        if (memreq_rdy) begin
          mem_q.push_back(memreq_type);
          last_mt = memreq_type;
          req_seen = 0; pending = 1; resp_wait = 0;
        end else begin
          req_seen++;
        end
      end
      if (data_array_wen) begin
        chk("wben", data_array_wben, 16'hffff);
        chk("wr_way", way_sel, way);
        if (is_refill) begin
          n_refill++;
          chk("refill_tag_wen", {tag_array_1_wen, tag_array_0_wen}, way ? 2'b10 : 2'b01);
        end else begin
          n_wr++;
          chk("amo_sel", amo_sel, is_amo ? typ - 3'd2 : 3'd0);
          chk("wr_tag_wen", {tag_array_1_wen, tag_array_0_wen},
              (!hit && is_wr) ? (way ? 2'b10 : 2'b01) : 2'b00);
        end
      end
      if (read_tag_reg_en) begin
        n_evrd++;
        chk("evict_way", way_sel, way);
      end
      if (cacheresp_val) begin
        if (cr_seen == 0) chk("latency", cyc, exp_resp);
        chk("resp_type", cacheresp_type, typ);
        if (cacheresp_rdy) done = 1;
        else cr_seen++;
      end
      @(posedge clk); #1;
      cyc++;
    end
    chk("resp_timeout", done, 1);
    cacheresp_rdy = 1'b0;
    memresp_val   = 1'b0;
    chk("n_memreq", mem_q.size(), exp_q.size());
    for (int i = 0; i < mem_q.size() && i < exp_q.size(); i++)
      chk("memreq_type", mem_q[i], exp_q[i]);
    chk("n_refill_wr", n_refill, refill);
    chk("n_access_wr", n_wr, typ != T_READ);
    chk("n_evict_rd", n_evrd, evict);

    if (!hit) begin
      m_tag[idx][way]   = tg;
      m_val[idx][way]   = 1'b1;
      m_dirty[idx][way] = 1'b0;
    end
    if (typ == T_WRITE || is_amo) m_dirty[idx][way] = 1'b1;
    else if (typ == T_INIT)       m_dirty[idx][way] = 1'b0;
    m_lru[idx] = !way;
  endtask

  initial begin
    int unsigned n;
    for (int s = 0; s < 8; s++)
      for (int w = 0; w < 2; w++) m_tag[s][w] = '1;
    model_reset();
    reset = 1'b0;
    cachereq_val = 1'b1; cachereq_type = T_READ; cachereq_addr = '0;
    memreq_rdy = 1'b0; memresp_val = 1'b1; cacheresp_rdy = 1'b0;
    #1;
    chk("reset_outs", outs, 0);
    cachereq_val = 1'b0; memresp_val = 1'b0;
    @(posedge clk); #1;
    reset = 1'b1;
    @(posedge clk); #1;

    // INIT then read hit, cold read miss then hits
    txn(T_INIT,  32'h1000, 0, 0, 0);
    txn(T_READ,  32'h1000, 0, 0, 0);
    txn(T_READ,  32'h2000, 0, 2, 0);
    txn(T_READ,  32'h2000, 0, 0, 0);
    txn(T_READ,  32'h2000, 0, 0, 1);
    // Two dirty lines in set 0, then a conflicting read forces a write-back
    txn(T_WRITE, 32'h0000, 0, 0, 0);
    txn(T_WRITE, 32'h0080, 0, 0, 0);
    txn(T_READ,  32'h0000, 0, 0, 0);
    txn(T_READ,  32'h0100, 1, 1, 0);
    // AMOs on a hit and on a miss
    txn(T_WRITE, 32'h3000, 0, 0, 0);
    txn(T_ADD,   32'h3000, 0, 0, 0);
    txn(T_READ,  32'h3000, 0, 0, 0);
    txn(T_OR,    32'h3040, 0, 1, 0);
    txn(T_AND,   32'h3040, 0, 0, 0);
    // Backpressure on both response and memory request paths
    txn(T_READ,  32'h3000, 0, 0, 10);
    txn(T_READ,  32'h4000, 3, 2, 0);

    // Reset in REFILL_WAIT on untouched set 7
    txn(T_READ, 32'h5070, 0, 0, 0);
    cachereq_type = T_READ; cachereq_addr = 32'h6070; cachereq_val = 1'b1;
    memreq_rdy = 1'b1; memresp_val = 1'b0; cacheresp_rdy = 1'b0;
    #1;
    chk("abort_accept", cachereq_rdy, 1);
    @(posedge clk); #1;
    cachereq_val = 1'b0;
    n = 0;
    while (!(memreq_val && memreq_rdy) && n < 20) begin
      @(posedge clk); #1;
      n++;
    end
    chk("abort_reach_memreq", n < 20, 1);
    chk("abort_memreq_type", memreq_type, T_READ);
    @(posedge clk); #1;
    chk("abort_in_wait", memresp_rdy, 1);
    reset = 1'b0;
    #1;
    chk("abort_outs", outs, 0);
    model_reset();
    @(posedge clk); #1;
    @(posedge clk); #1;
    reset = 1'b1;
    @(posedge clk); #1;
    txn(T_READ, 32'h5070, 0, 0, 0);
    txn(T_READ, 32'h6070, 0, 1, 0);
    txn(T_READ, 32'h6070, 0, 0, 0);

    for (int i = 0; i < 40; i++)
      txn(3'($urandom_range(0, 5)),
          ($urandom_range(0, 3) << 7) | ($urandom_range(0, 7) << 4),
          $urandom_range(0, 2), $urandom_range(0, 2), $urandom_range(0, 2));

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
